// File: rtl/sdrc_wb_arbiter.sv
// sdrc_wb_arbiter
// Round-robin arbiter that shares the single Wishbone slave port of sdrc_top
// among NUM_MASTERS requesters. A grant is held for the whole wb_cyc, so a
// linear burst is never split between masters. A per-grant watchdog aborts a
// transfer that waits too long for an ack and pulses the owner's m_err_o.
//
// Ports
//   wb_clk_i / wb_rst_i : clock, asynchronous active-high reset
//   m_*_i               : flattened master request buses, master k in slice k
//   m_ack_o / m_err_o   : per-master ack and timeout-error pulse
//   m_dat_o             : slave read data, broadcast to every master
//   s_*_o / s_*_i       : slave-side bus towards sdrc_top
//   grant_o             : one-hot owner; all-zero while idle
module sdrc_wb_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int APP_AW      = 26,
  parameter int DW          = 32,
  parameter int BW          = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*APP_AW-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*BW-1:0]     m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [DW-1:0]                 m_dat_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [APP_AW-1:0]             s_addr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [BW-1:0]                 s_sel_o,
  output logic [2:0]                    s_cti_o,
  input  logic                          s_ack_i,
  input  logic [DW-1:0]                 s_dat_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;     // last winner; also the current owner index
  logic [CW-1:0] wdog_q, wdog_d;

  logic          busy, gnt_cyc, expire, win_found;
  logic [PW-1:0] win_idx;
  int            j;

  assign busy    = (state_q == S_BUSY);
  assign gnt_cyc = m_cyc_i[ptr_q];
  assign grant_o = (state_q == S_IDLE) ? '0 : (NUM_MASTERS'(1) << ptr_q);

  // Slave-side mux: only the owner drives the slave, and only while BUSY.
  assign s_cyc_o  = busy & gnt_cyc;
  assign s_stb_o  = busy & m_stb_i[ptr_q];
  assign s_we_o   = busy & m_we_i[ptr_q];
  assign s_addr_o = busy ? m_addr_i[ptr_q*APP_AW +: APP_AW] : '0;
  assign s_dat_o  = busy ? m_dat_i[ptr_q*DW +: DW] : '0;
  assign s_sel_o  = busy ? m_sel_i[ptr_q*BW +: BW] : '0;
  assign s_cti_o  = busy ? m_cti_i[ptr_q*3 +: 3] : '0;

  // Acks seen outside BUSY are dropped rather than forwarded.
  assign m_ack_o = busy ? (grant_o & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_dat_o = s_dat_i;

  // A coincident ack beats expiry, so the error is only raised ack-less.
  assign expire  = (TIMEOUT_CYC != 0) && busy && s_stb_o && !s_ack_i &&
                   (wdog_q == CW'(TIMEOUT_CYC - 1));
  assign m_err_o = expire ? grant_o : '0;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!win_found && m_cyc_i[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wdog_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_BUSY;
          ptr_d   = win_idx;
        end
      end
      S_BUSY: begin
        if (!gnt_cyc)    state_d = S_IDLE;
        else if (expire) state_d = S_ABORT;
        // Count stalled strobe cycles; saturate instead of wrapping.
        if (TIMEOUT_CYC != 0 && s_stb_o && !s_ack_i && wdog_q != '1)
          wdog_d = wdog_q + 1'b1;
      end
      S_ABORT: begin
        if (!gnt_cyc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NUM_MASTERS - 1);   // master 0 wins the first round
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
module tb_sdrc_wb_arbiter;
  localparam int NM = 2;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*BW-1:0]  m_sel_i;
  logic [NM*3-1:0]   m_cti_i;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]     m_dat_o, s_dat_o, s_dat_i;
  logic              s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0]     s_addr_o;
  logic [BW-1:0]     s_sel_o;
  logic [2:0]        s_cti_o;

  int checks = 0;
  int failures = 0;
  int ack1_cnt, ack0_cnt, err_early;

  always #5 wb_clk_i = ~wb_clk_i;

  sdrc_wb_arbiter #(.NUM_MASTERS(NM), .APP_AW(AW), .DW(DW), .BW(BW), .TIMEOUT_CYC(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 1 ns later.
  task automatic step();
    @(negedge wb_clk_i);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_addr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    #12;
    chk("rst_scyc", 64'(s_cyc_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_ack", 64'(m_ack_o), 64'd0);
    chk("rst_err", 64'(m_err_o), 64'd0);
    step(); wb_rst_i = 1'b0;

    // Ack in IDLE is not forwarded
    step(); s_ack_i = 1'b1; #1;
    chk("idle_ack_drop", 64'(m_ack_o), 64'd0);
    s_ack_i = 1'b0;

    // Single master 0 write
    step();
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
    m_addr_i[0 +: AW] = 26'h0000010; m_dat_i[0 +: DW] = 32'hDEADBEEF; m_sel_i[0 +: BW] = 4'hF;
    #1 chk("wr_latency0", 64'(s_cyc_o), 64'd0);
    step(); #1;
    chk("wr_scyc", 64'(s_cyc_o), 64'd1);
    chk("wr_grant", 64'(grant_o), 64'b01);
    chk("wr_addr", 64'(s_addr_o), 64'h10);
    chk("wr_dat", 64'(s_dat_o), 64'hDEADBEEF);
    chk("wr_we_sel", 64'({s_we_o, s_sel_o}), 64'h1F);
    chk("wr_noack", 64'(m_ack_o), 64'd0);
    s_ack_i = 1'b1; #1;
    chk("wr_ack", 64'(m_ack_o), 64'b01);
    step(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    step(); m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step(); s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF; #1;
    chk("rd_we", 64'(s_we_o), 64'd0);
    chk("rd_ack", 64'(m_ack_o), 64'b01);
    chk("rd_dat", 64'(m_dat_o), 64'hDEADBEEF);
    step(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;

    // Reset, then simultaneous requests alternate strictly
    step(); wb_rst_i = 1'b1;
    step(); wb_rst_i = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step(); #1 chk("rr_first", 64'(grant_o), 64'b01);
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step(); #1;
    chk("rr_gap_grant", 64'(grant_o), 64'd0);
    chk("rr_gap_cyc", 64'(s_cyc_o), 64'd0);
    step(); #1 chk("rr_second", 64'(grant_o), 64'b10);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step(); m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step(); #1 chk("rr_third", 64'(grant_o), 64'b01);
    m_cyc_i = '0; m_stb_i = '0;
    step();

    // Master 1 8-beat burst, master 0 arrives mid-burst
    step();
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_cti_i[3 +: 3] = 3'b010;
    m_addr_i[AW +: AW] = 26'h0000100;
    step(); #1 chk("bu_grant", 64'(grant_o), 64'b10);
    chk("bu_cti", 64'(s_cti_o), 64'b010);
    ack1_cnt = 0; ack0_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      if (b > 0) step();
      if (b == 3) begin m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; end
      if (b == 7) m_cti_i[3 +: 3] = 3'b111;
      s_ack_i = 1'b1; #1;
      if (m_ack_o[1]) ack1_cnt++;
      if (m_ack_o[0]) ack0_cnt++;
    end
    chk("bu_last_cti", 64'(s_cti_o), 64'b111);
    chk("bu_ack1", 64'(ack1_cnt), 64'd8);
    chk("bu_ack0", 64'(ack0_cnt), 64'd0);
    chk("bu_hold", 64'(grant_o), 64'b10);
    step(); s_ack_i = 1'b0; m_cyc_i = 2'b01; m_stb_i = 2'b01; m_cti_i = '0;
    step(); #1 chk("bu_gap", 64'(grant_o), 64'd0);
    step(); #1 chk("bu_m0", 64'(grant_o), 64'b01);
    m_cyc_i = '0; m_stb_i = '0;
    step();

    // Watchdog: slave never acks
    step(); m_cyc_i = 2'b01; m_stb_i = 2'b01;
    err_early = 0;
    for (int k = 1; k <= 15; k++) begin
      step(); #1;
      if (m_err_o != 2'b00) err_early++;
    end
    chk("wd_no_early_err", 64'(err_early), 64'd0);
    step(); #1;
    chk("wd_err", 64'(m_err_o), 64'b01);
    chk("wd_cyc_at_err", 64'(s_cyc_o), 64'd1);
    step(); #1;
    chk("wd_cyc_drop", 64'(s_cyc_o), 64'd0);
    chk("wd_err_pulse", 64'(m_err_o), 64'd0);
    chk("wd_abort_grant", 64'(grant_o), 64'b01);
    s_ack_i = 1'b1; #1;
    chk("wd_abort_ack", 64'(m_ack_o), 64'd0);
    s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    step(); #1 chk("wd_idle", 64'(grant_o), 64'd0);

    // Async reset mid-burst with both masters requesting
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_cti_i[3 +: 3] = 3'b010;
    step(); #1 chk("ar_grant", 64'(grant_o), 64'b10);
    m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
    #2 wb_rst_i = 1'b1; #1;
    chk("ar_cyc", 64'(s_cyc_o), 64'd0);
    chk("ar_grant0", 64'(grant_o), 64'd0);
    chk("ar_ack", 64'(m_ack_o), 64'd0);
    chk("ar_addr", 64'(s_addr_o), 64'd0);
    step(); wb_rst_i = 1'b0; s_ack_i = 1'b0;
    step(); #1 chk("ar_m0_wins", 64'(grant_o), 64'b01);
    m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0;
    step(); wb_rst_i = 1'b1;
    step(); wb_rst_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step(); #1 chk("ar_m1_alone", 64'(grant_o), 64'b10);
    m_cyc_i = '0; m_stb_i = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "bench timed out");
  end
endmodule
